// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// Also runs a sweep that zeroes every register, one per cycle, on clear_start.
module regfile_write_arbiter #(
    parameter int WORD_SIZE        = 16,
    parameter int COUNT            = 32,
    parameter int NUM_REQ          = 4,
    parameter bit ZERO_REG_PROTECT = 1'b0,
    localparam int COUNT_BITS      = $clog2(COUNT),
    localparam int REQ_BITS        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*COUNT_BITS-1:0] req_idx,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
    input  logic                          clear_start,
    output logic                          clear_busy,
    output logic [WORD_SIZE-1:0]          data_in,
    output logic [COUNT_BITS-1:0]         idx_write,
    output logic                          en_write,
    output logic [REQ_BITS-1:0]           grant_id
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]            state;
    logic [REQ_BITS-1:0]   rr_ptr;
    logic [COUNT_BITS-1:0] clr_cnt;

    logic                  found;
    logic [REQ_BITS-1:0]   winner;
    logic [REQ_BITS-1:0]   cand;
    logic [REQ_BITS:0]     wrap_sum;
    logic                  accept;
    logic [COUNT_BITS-1:0] win_idx;
    logic [WORD_SIZE-1:0]  win_data;
    logic                  zero_blocked;
    logic [REQ_BITS-1:0]   rr_next;

    // Scan starts at rr_ptr and wraps modulo NUM_REQ; the first valid requester wins.
    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        wrap_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            wrap_sum = {1'b0, rr_ptr} + (REQ_BITS+1)'(k);
            if (wrap_sum >= (REQ_BITS+1)'(NUM_REQ)) begin
                wrap_sum = wrap_sum - (REQ_BITS+1)'(NUM_REQ);
            end
            cand = wrap_sum[REQ_BITS-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A pending clear takes priority over any request in the same cycle.
    assign accept       = (state == ST_IDLE) && !clear_start && found;
    assign req_ready    = accept ? (NUM_REQ'(1) << winner) : '0;
    assign win_idx      = req_idx[int'(winner)*COUNT_BITS +: COUNT_BITS];
    assign win_data     = req_data[int'(winner)*WORD_SIZE +: WORD_SIZE];
    assign zero_blocked = ZERO_REG_PROTECT && (win_idx == '0);
    assign rr_next      = (winner == REQ_BITS'(NUM_REQ-1)) ? '0 : winner + 1'b1;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            data_in    <= '0;
            idx_write  <= '0;
            en_write   <= 1'b0;
            grant_id   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        // The entry edge already presents the first sweep write (idx 0).
                        state      <= ST_CLEAR;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                        en_write   <= 1'b1;
                        idx_write  <= '0;
                        data_in    <= '0;
                        grant_id   <= '0;
                    end else if (accept) begin
                        rr_ptr <= rr_next;
                        if (zero_blocked) begin
                            en_write <= 1'b0;
                        end else begin
                            en_write  <= 1'b1;
                            idx_write <= win_idx;
                            data_in   <= win_data;
                            grant_id  <= winner;
                        end
                    end else begin
                        en_write <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == COUNT_BITS'(COUNT-1)) begin
                        state      <= ST_IDLE;
                        clear_busy <= 1'b0;
                        en_write   <= 1'b0;
                    end else begin
                        clr_cnt   <= clr_cnt + 1'b1;
                        en_write  <= 1'b1;
                        idx_write <= clr_cnt + 1'b1;
                        data_in   <= '0;
                        grant_id  <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    en_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: two arbiters (unprotected and ZERO_REG_PROTECT=1) share stimulus;
// expected register-file writes are queued per DUT and checked by a negedge monitor.
module tb_regfile_write_arbiter;

    localparam int WS  = 16;
    localparam int CNT = 32;
    localparam int NR  = 4;
    localparam int CB  = 5;
    localparam int RB  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid;
    logic             clear_start;
    logic [NR*CB-1:0] req_idx;
    logic [NR*WS-1:0] req_data;
    logic [CB-1:0]    idx_v [NR];
    logic [WS-1:0]    data_v[NR];

    always_comb begin
        req_idx  = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_idx[i*CB +: CB]  = idx_v[i];
            req_data[i*WS +: WS] = data_v[i];
        end
    end

    logic [NR-1:0] rdy_a, rdy_p;
    logic          busy_a, busy_p, en_a, en_p;
    logic [WS-1:0] din_a, din_p;
    logic [CB-1:0] idx_a, idx_p;
    logic [RB-1:0] gid_a, gid_p;

    regfile_write_arbiter #(.WORD_SIZE(WS), .COUNT(CNT), .NUM_REQ(NR), .ZERO_REG_PROTECT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
        .req_idx(req_idx), .req_data(req_data), .clear_start(clear_start),
        .clear_busy(busy_a), .data_in(din_a), .idx_write(idx_a),
        .en_write(en_a), .grant_id(gid_a)
    );

    regfile_write_arbiter #(.WORD_SIZE(WS), .COUNT(CNT), .NUM_REQ(NR), .ZERO_REG_PROTECT(1'b1)) dut_p (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_p),
        .req_idx(req_idx), .req_data(req_data), .clear_start(clear_start),
        .clear_busy(busy_p), .data_in(din_p), .idx_write(idx_p),
        .en_write(en_p), .grant_id(gid_p)
    );

    typedef struct {
        int            cyc;
        logic [CB-1:0] idx;
        logic [WS-1:0] data;
        logic [RB-1:0] gid;
    } exp_t;

    exp_t q_a[$];
    exp_t q_p[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_write(input string tag, input exp_t e, input int now,
                             input logic [CB-1:0] idx, input logic [WS-1:0] data,
                             input logic [RB-1:0] gid);
        check({tag, " write cycle"}, 32'(now), 32'(e.cyc));
        check({tag, " idx_write"},   32'(idx), 32'(e.idx));
        check({tag, " data_in"},     32'(data), 32'(e.data));
        check({tag, " grant_id"},    32'(gid), 32'(e.gid));
    endtask

    // Monitor: every en_write pulse must match the oldest queued write, on its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (en_a) begin
                if (q_a.size() == 0) check("a unexpected en_write", 32'(en_a), 32'd0);
                else begin
                    e = q_a.pop_front();
                    cmp_write("a", e, cyc, idx_a, din_a, gid_a);
                end
            end else if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
                check("a missing write", 32'(en_a), 32'd1);
                void'(q_a.pop_front());
            end
            if (en_p) begin
                if (q_p.size() == 0) check("p unexpected en_write", 32'(en_p), 32'd0);
                else begin
                    e = q_p.pop_front();
                    cmp_write("p", e, cyc, idx_p, din_p, gid_p);
                end
            end else if (q_p.size() > 0 && q_p[0].cyc <= cyc) begin
                check("p missing write", 32'(en_p), 32'd1);
                void'(q_p.pop_front());
            end
        end
    end

    // One clock cycle of stimulus: drive, check ready/busy at negedge, queue expected writes.
    task automatic step(input logic [NR-1:0] v, input logic cs, input logic [NR-1:0] exp_rdy,
                        input logic exp_busy, input bit sweep, input string name);
        req_valid   = v;
        clear_start = cs;
        @(negedge clk);
        check({name, " ready a"}, 32'(rdy_a), 32'(exp_rdy));
        check({name, " ready p"}, 32'(rdy_p), 32'(exp_rdy));
        check({name, " busy a"},  32'(busy_a), 32'(exp_busy));
        check({name, " busy p"},  32'(busy_p), 32'(exp_busy));
        for (int i = 0; i < NR; i++) begin
            if (exp_rdy[i]) begin
                q_a.push_back('{cyc + 1, idx_v[i], data_v[i], RB'(i)});
                if (idx_v[i] != '0) q_p.push_back('{cyc + 1, idx_v[i], data_v[i], RB'(i)});
            end
        end
        if (sweep) begin
            for (int k = 0; k < CNT; k++) begin
                q_a.push_back('{cyc + 1 + k, CB'(k), '0, '0});
                q_p.push_back('{cyc + 1 + k, CB'(k), '0, '0});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid   = '0;
        clear_start = 1'b0;
        idx_v  = '{5'd3, 5'd7, 5'd9, 5'd12};
        data_v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        repeat (2) @(posedge clk);
        #1;
        check("reset en_write a",   32'(en_a),   32'd0);
        check("reset idx_write a",  32'(idx_a),  32'd0);
        check("reset data_in a",    32'(din_a),  32'd0);
        check("reset grant_id a",   32'(gid_a),  32'd0);
        check("reset clear_busy a", 32'(busy_a), 32'd0);
        check("reset en_write p",   32'(en_p),   32'd0);
        check("reset clear_busy p", 32'(busy_p), 32'd0);
        rst = 1'b1;

        // Round robin from reset: all four held valid.
        for (int k = 0; k < 8; k++) step(4'b1111, 1'b0, NR'(1) << (k % 4), 1'b0, 1'b0, "rr");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "idle");

        // Single writer: requester 2, idx 5, data 0xBEEF; next cycle must be quiet.
        idx_v[2]  = 5'd5;
        data_v[2] = 16'hBEEF;
        step(4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, "single");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "single idle");

        // Starvation: rr_ptr 3 -> grant 0 (rr_ptr 1), then 0 and 3 valid: 3 wins first.
        step(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, "starve set");
        step(4'b1001, 1'b0, 4'b1000, 1'b0, 1'b0, "starve 3 first");
        step(4'b1001, 1'b0, 4'b0001, 1'b0, 1'b0, "starve 0");
        step(4'b1001, 1'b0, 4'b1000, 1'b0, 1'b0, "starve 3 again");

        // Protection: requester 1 writes idx 0; protected DUT must still advance rr_ptr.
        idx_v[1]  = 5'd0;
        data_v[1] = 16'h1234;
        idx_v[2]  = 5'd20;
        data_v[2] = 16'h5A5A;
        step(4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, "zero write");
        step(4'b0110, 1'b0, 4'b0100, 1'b0, 1'b0, "after zero");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "idle");

        // Clear with requester 1 pending; a second clear_start mid-sweep is ignored.
        idx_v[1]  = 5'd17;
        data_v[1] = 16'hC0DE;
        step(4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, "clear start");
        for (int k = 0; k < CNT; k++) step(4'b0010, (k == 5), 4'b0000, 1'b1, 1'b0, "clearing");
        step(4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, "first idle");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "idle");

        // Reset mid-clear at sweep idx 10.
        step(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, "clear2 start");
        for (int k = 0; k < 10; k++) step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "clear2");
        check("sweep idx before reset", 32'(idx_a), 32'd10);
        rst = 1'b0;
        q_a.delete();
        q_p.delete();
        #1;
        check("mid reset en_write a",   32'(en_a),   32'd0);
        check("mid reset clear_busy a", 32'(busy_a), 32'd0);
        check("mid reset en_write p",   32'(en_p),   32'd0);
        check("mid reset clear_busy p", 32'(busy_p), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0, "post reset");
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "drain");

        check("a queue empty", 32'(q_a.size()), 32'd0);
        check("p queue empty", 32'(q_p.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
